store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 61 ++++++
 rtl/store_buffer_snoop.sv | 54 +++++
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : store_buffer_pkg
// Brief  : Shared store-buffer types and byte-mask helpers.
// Rev    : 1.0  initial release
// ============================================================================
package store_buffer_pkg;

    typedef enum logic [1:0] {
        ACCESS_BYTE = 2'd0,
        ACCESS_HALF = 2'd1,
        ACCESS_WORD = 2'd2
    } cache_access_size_t;

    // Data is kept in its word lanes so snoop and drain need no realignment of the mask.
    typedef struct packed {
        logic        valid;
        logic [29:0] word_addr;
        logic [3:0]  byte_mask;
        logic [31:0] data;
    } store_buffer_entry_t;

    function automatic logic [3:0] size_to_mask(input cache_access_size_t size,
                                                input logic [1:0]         offset);
        logic [3:0] base;
        case (size)
            ACCESS_BYTE: base = 4'b0001;
            ACCESS_HALF: base = 4'b0011;
            default:     base = 4'b1111;
        endcase
        return base << offset;
    endfunction

    function automatic logic [31:0] mask_to_bits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

    // Accesses are naturally aligned, so the mask alone recovers offset and size.
    function automatic logic [1:0] mask_to_offset(input logic [3:0] mask);
        logic [1:0] off;
        casez (mask)
            4'b???1: off = 2'd0;
            4'b??10: off = 2'd1;
            4'b?100: off = 2'd2;
            default: off = 2'd3;
        endcase
        return off;
    endfunction

    function automatic cache_access_size_t mask_to_size(input logic [3:0] mask);
        cache_access_size_t sz;
        case (mask)
            4'b1111:          sz = ACCESS_WORD;
            4'b0011, 4'b1100: sz = ACCESS_HALF;
            default:          sz = ACCESS_BYTE;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_snoop.sv
`default_nettype none
// ============================================================================
// Module : store_buffer_snoop
// Brief  : Youngest-overlapping-entry select and load forwarding check.
// Rev    : 1.0  initial release
// ============================================================================
module store_buffer_snoop
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  store_buffer_entry_t        entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [31:0]                snoop_addr_i,
    input  cache_access_size_t         snoop_size_i,
    output logic                       snoop_hit_o,
    output logic [31:0]                snoop_data_o,
    output logic                       snoop_conflict_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [3:0]          load_mask;
    logic                found;
    logic                covered;
    store_buffer_entry_t young;
    logic [PTR_W-1:0]    idx;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        load_mask = size_to_mask(snoop_size_i, snoop_addr_i[1:0]);
        found     = 1'b0;
        young     = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (entries_i[idx].valid &&
                (entries_i[idx].word_addr == snoop_addr_i[31:2]) &&
                (|(entries_i[idx].byte_mask & load_mask))) begin
                found = 1'b1;
                young = entries_i[idx];
            end
        end
    end

    assign covered          = found && ((young.byte_mask & load_mask) == load_mask);
    assign snoop_hit_o      = covered;
    assign snoop_conflict_o = found && !covered;
    assign snoop_data_o     = covered
        ? ((young.data >> {snoop_addr_i[1:0], 3'b000}) & mask_to_bits(size_to_mask(snoop_size_i, 2'b00)))
        : 32'd0;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module : store_buffer
// Brief  : Circular store FIFO between MEM stage and dcache with load snoop.
// Rev    : 1.0  initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               put_enable_i,
    input  logic [31:0]        put_addr_i,
    input  logic [31:0]        put_data_i,
    input  cache_access_size_t put_size_i,
    output logic               full_o,
    output logic               empty_o,
    output logic               get_valid_o,
    input  logic               get_ready_i,
    output logic [31:0]        get_addr_o,
    output logic [31:0]        get_data_o,
    output cache_access_size_t get_size_o,
    input  logic [31:0]        snoop_addr_i,
    input  cache_access_size_t snoop_size_i,
    output logic               snoop_hit_o,
    output logic [31:0]        snoop_data_o,
    output logic               snoop_conflict_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    store_buffer_entry_t entries_q [DEPTH];
    store_buffer_entry_t entries_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                is_full, is_empty, do_put, do_pop;
    logic [3:0]          put_mask;
    store_buffer_entry_t head_entry;
    logic                snp_hit, snp_conflict;
    logic [31:0]         snp_data;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign do_put   = put_enable_i && !is_full;
    assign do_pop   = !is_empty && get_ready_i;
    assign put_mask = size_to_mask(put_size_i, put_addr_i[1:0]);

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (do_put) begin
            entries_d[tail_q].valid     = 1'b1;
            entries_d[tail_q].word_addr = put_addr_i[31:2];
            entries_d[tail_q].byte_mask = put_mask;
            entries_d[tail_q].data      = (put_data_i << {put_addr_i[1:0], 3'b000}) & mask_to_bits(put_mask);
            tail_d                      = tail_q + 1'b1;
        end
        if (do_pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_put) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    // Outputs are forced to their idle values for the whole reset cycle, not just after it.
    assign full_o      = !reset_i && is_full;
    assign empty_o     = reset_i || is_empty;
    assign get_valid_o = !empty_o;

    assign head_entry  = entries_q[head_q];
    assign get_size_o  = mask_to_size(head_entry.byte_mask);
    assign get_addr_o  = {head_entry.word_addr, mask_to_offset(head_entry.byte_mask)};
    assign get_data_o  = (head_entry.data >> {mask_to_offset(head_entry.byte_mask), 3'b000})
                         & mask_to_bits(size_to_mask(get_size_o, 2'b00));

    store_buffer_snoop #(
        .DEPTH (DEPTH)
    ) u_snoop (
        .entries_i        (entries_q),
        .head_i           (head_q),
        .snoop_addr_i     (snoop_addr_i),
        .snoop_size_i     (snoop_size_i),
        .snoop_hit_o      (snp_hit),
        .snoop_data_o     (snp_data),
        .snoop_conflict_o (snp_conflict)
    );

    assign snoop_hit_o      = !reset_i && snp_hit;
    assign snoop_conflict_o = !reset_i && snp_conflict;
    assign snoop_data_o     = reset_i ? 32'd0 : snp_data;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_store_buffer
// Brief  : Scoreboard bench for store_buffer with a byte-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic               put_enable_i;
    logic [31:0]        put_addr_i;
    logic [31:0]        put_data_i;
    cache_access_size_t put_size_i;
    logic               full_o, empty_o, get_valid_o;
    logic               get_ready_i;
    logic [31:0]        get_addr_o, get_data_o;
    cache_access_size_t get_size_o;
    logic [31:0]        snoop_addr_i;
    cache_access_size_t snoop_size_i;
    logic               snoop_hit_o, snoop_conflict_o;
    logic [31:0]        snoop_data_o;

    typedef struct {
        logic [31:0]        addr;
        logic [31:0]        data;
        cache_access_size_t size;
    } st_t;

    st_t mdl_q[$];
    st_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #10 clk_i = ~clk_i;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .put_enable_i     (put_enable_i),
        .put_addr_i       (put_addr_i),
        .put_data_i       (put_data_i),
        .put_size_i       (put_size_i),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .get_valid_o      (get_valid_o),
        .get_ready_i      (get_ready_i),
        .get_addr_o       (get_addr_o),
        .get_data_o       (get_data_o),
        .get_size_o       (get_size_o),
        .snoop_addr_i     (snoop_addr_i),
        .snoop_size_i     (snoop_size_i),
        .snoop_hit_o      (snoop_hit_o),
        .snoop_data_o     (snoop_data_o),
        .snoop_conflict_o (snoop_conflict_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input cache_access_size_t s);
        case (s)
            ACCESS_BYTE: return 1;
            ACCESS_HALF: return 2;
            default:     return 4;
        endcase
    endfunction

    function automatic logic [31:0] low_bits(input cache_access_size_t s);
        case (s)
            ACCESS_BYTE: return 32'h0000_00FF;
            ACCESS_HALF: return 32'h0000_FFFF;
            default:     return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Byte-range view: scan pending stores youngest first, first overlap decides.
    function automatic void ref_snoop(input logic [31:0] la, input cache_access_size_t ls,
                                      output bit hit, output bit conf, output logic [31:0] data);
        int lo, ln, so, sn;
        hit = 0; conf = 0; data = 32'd0;
        lo = int'(la[1:0]);
        ln = nbytes(ls);
        for (int i = mdl_q.size() - 1; i >= 0; i--) begin
            so = int'(mdl_q[i].addr[1:0]);
            sn = nbytes(mdl_q[i].size);
            if (mdl_q[i].addr[31:2] == la[31:2] && lo < so + sn && so < lo + ln) begin
                if (lo >= so && lo + ln <= so + sn) begin
                    hit = 1;
                    for (int k = 0; k < ln; k++)
                        data = data | (((mdl_q[i].data >> (8 * (lo - so + k))) & 32'hFF) << (8 * k));
                end else begin
                    conf = 1;
                end
                return;
            end
        end
    endfunction

    // Reference model: occupancy and snoop checks, then apply this cycle's put/pop.
    always @(negedge clk_i) begin
        bit          e_hit, e_conf;
        logic [31:0] e_data;
        bit          accept, pop;
        st_t         s;
        if (reset_i === 1'b1) begin
            check("rst_empty", 32'(empty_o), 32'd1);
            check("rst_full", 32'(full_o), 32'd0);
            check("rst_valid", 32'(get_valid_o), 32'd0);
            check("rst_hit", 32'(snoop_hit_o), 32'd0);
            check("rst_conflict", 32'(snoop_conflict_o), 32'd0);
            mdl_q.delete();
            exp_q.delete();
        end else if (reset_i === 1'b0) begin
            check("full", 32'(full_o), 32'(mdl_q.size() == DEPTH));
            check("empty", 32'(empty_o), 32'(mdl_q.size() == 0));
            check("get_valid", 32'(get_valid_o), 32'(mdl_q.size() != 0));
            ref_snoop(snoop_addr_i, snoop_size_i, e_hit, e_conf, e_data);
            check("snoop_hit", 32'(snoop_hit_o), 32'(e_hit));
            check("snoop_conflict", 32'(snoop_conflict_o), 32'(e_conf));
            check("snoop_data", snoop_data_o, e_data);
            accept = put_enable_i && (mdl_q.size() < DEPTH);
            pop    = get_ready_i && (mdl_q.size() > 0);
            if (pop) void'(mdl_q.pop_front());
            if (accept) begin
                s.addr = put_addr_i;
                s.data = put_data_i & low_bits(put_size_i);
                s.size = put_size_i;
                mdl_q.push_back(s);
                exp_q.push_back(s);
            end
        end
    end

    // Drain monitor: each dcache handshake pops the scoreboard.
    always @(negedge clk_i) begin
        st_t e;
        if (reset_i === 1'b0 && get_valid_o && get_ready_i) begin
            if (exp_q.size() == 0) begin
                check("get_unexpected", 32'(get_valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("get_addr", get_addr_o, e.addr);
                check("get_data", get_data_o, e.data);
                check("get_size", 32'(get_size_o), 32'(e.size));
            end
        end
    end

    task automatic cyc(input bit rst, input bit pe, input logic [31:0] a, input logic [31:0] d,
                       input cache_access_size_t s, input bit rdy);
        reset_i      = rst;
        put_enable_i = pe;
        put_addr_i   = a;
        put_data_i   = d;
        put_size_i   = s;
        get_ready_i  = rdy;
        @(posedge clk_i);
        #2;
        reset_i      = 1'b0;
        put_enable_i = 1'b0;
        get_ready_i  = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr(input cache_access_size_t s);
        logic [31:0] base;
        base = 32'h300 + 32'(4 * $urandom_range(0, 3));
        case (s)
            ACCESS_BYTE: return base + 32'($urandom_range(0, 3));
            ACCESS_HALF: return base + 32'(2 * $urandom_range(0, 1));
            default:     return base;
        endcase
    endfunction

    function automatic cache_access_size_t rand_size();
        case ($urandom_range(0, 2))
            0:       return ACCESS_BYTE;
            1:       return ACCESS_HALF;
            default: return ACCESS_WORD;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rdy_pct;
        reset_i      = 1'b1;
        put_enable_i = 1'b0;
        put_addr_i   = '0;
        put_data_i   = '0;
        put_size_i   = ACCESS_WORD;
        get_ready_i  = 1'b0;
        snoop_addr_i = 32'h200;
        snoop_size_i = ACCESS_WORD;
        repeat (3) @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        #1;
        check("init_empty", 32'(empty_o), 32'd1);
        check("init_full", 32'(full_o), 32'd0);

        // Single word store flows through with one cycle of latency.
        cyc(0, 1, 32'h100, 32'hDEAD_BEEF, ACCESS_WORD, 0);
        #1;
        check("sw_valid", 32'(get_valid_o), 32'd1);
        check("sw_addr", get_addr_o, 32'h100);
        check("sw_data", get_data_o, 32'hDEAD_BEEF);
        cyc(0, 0, 32'h0, 32'h0, ACCESS_WORD, 1);
        #1;
        check("sw_drained", 32'(empty_o), 32'd1);

        // Fill, overflow put, in-order drain, pointer wrap.
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h400 + 32'(4 * i), 32'hA0 + 32'(i), ACCESS_WORD, 0);
        #1;
        check("fill_full", 32'(full_o), 32'd1);
        cyc(0, 1, 32'h500, 32'h55, ACCESS_WORD, 0);
        #1;
        check("overflow_full", 32'(full_o), 32'd1);
        check("overflow_head", get_addr_o, 32'h400);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_order", get_data_o, 32'hA0 + 32'(i));
            cyc(0, 0, 32'h0, 32'h0, ACCESS_WORD, 1);
        end
        #1;
        check("drain_empty", 32'(empty_o), 32'd1);
        cyc(0, 1, 32'h600, 32'h66, ACCESS_WORD, 0);
        #1;
        check("wrap_addr", get_addr_o, 32'h600);

        // Put and pop together with one entry: occupancy stays at one.
        cyc(0, 1, 32'h604, 32'h67, ACCESS_WORD, 1);
        #1;
        check("pp_head", get_addr_o, 32'h604);
        check("pp_not_empty", 32'(empty_o), 32'd0);
        cyc(0, 0, 32'h0, 32'h0, ACCESS_WORD, 1);

        // Full with put and pop: only the pop lands.
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h700 + 32'(4 * i), 32'h70 + 32'(i), ACCESS_WORD, 0);
        cyc(0, 1, 32'h800, 32'h80, ACCESS_WORD, 1);
        #1;
        check("fullpp_full", 32'(full_o), 32'd0);
        check("fullpp_head", get_addr_o, 32'h704);
        repeat (3) cyc(0, 0, 32'h0, 32'h0, ACCESS_WORD, 1);
        #1;
        check("fullpp_empty", 32'(empty_o), 32'd1);

        // Forwarding: word then overlapping byte.
        cyc(0, 1, 32'h200, 32'h1122_3344, ACCESS_WORD, 0);
        cyc(0, 1, 32'h201, 32'h0000_00AA, ACCESS_BYTE, 0);
        snoop_addr_i = 32'h201; snoop_size_i = ACCESS_BYTE;
        #1;
        check("lb_hit", 32'(snoop_hit_o), 32'd1);
        check("lb_data", snoop_data_o, 32'hAA);
        snoop_addr_i = 32'h200; snoop_size_i = ACCESS_WORD;
        #1;
        check("lw_conflict", 32'(snoop_conflict_o), 32'd1);
        check("lw_hit", 32'(snoop_hit_o), 32'd0);
        snoop_addr_i = 32'h202; snoop_size_i = ACCESS_HALF;
        #1;
        check("lh_hit", 32'(snoop_hit_o), 32'd1);
        check("lh_data", snoop_data_o, 32'h1122);

        // Reset with three pending entries and a concurrent put.
        cyc(0, 1, 32'h204, 32'h55, ACCESS_WORD, 0);
        snoop_addr_i = 32'h200; snoop_size_i = ACCESS_WORD;
        reset_i      = 1'b1;
        put_enable_i = 1'b1;
        put_addr_i   = 32'h208;
        put_size_i   = ACCESS_WORD;
        #1;
        check("inrst_empty", 32'(empty_o), 32'd1);
        check("inrst_conflict", 32'(snoop_conflict_o), 32'd0);
        @(posedge clk_i);
        #2;
        reset_i      = 1'b0;
        put_enable_i = 1'b0;
        #1;
        check("postrst_empty", 32'(empty_o), 32'd1);
        check("postrst_valid", 32'(get_valid_o), 32'd0);
        check("postrst_hit", 32'(snoop_hit_o), 32'd0);

        // Randomized traffic with varying drain pressure and rare resets.
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            cache_access_size_t s;
            if (c % 200 == 0) rdy_pct = (c / 200 % 3 == 0) ? 20 : ((c / 200 % 3 == 1) ? 80 : 50);
            s            = rand_size();
            reset_i      = ($urandom_range(0, 299) == 0);
            put_enable_i = ($urandom_range(0, 99) < 60);
            put_size_i   = s;
            put_addr_i   = rand_addr(s);
            put_data_i   = $urandom;
            get_ready_i  = ($urandom_range(0, 99) < rdy_pct);
            snoop_size_i = rand_size();
            snoop_addr_i = rand_addr(snoop_size_i);
            @(posedge clk_i);
            #2;
        end
        reset_i      = 1'b0;
        put_enable_i = 1'b0;
        get_ready_i  = 1'b1;
        repeat (DEPTH + 2) begin
            @(posedge clk_i);
            #2;
        end
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
